// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with conditional/unconditional
// PC-relative branches and a small circular return-address stack (RAS).
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   stall              freeze all state for this cycle
//   branch             conditional branch (CBZ/CBNZ) this cycle
//   branch_not_zero    0 = take when zero=1 (CBZ), 1 = take when zero=0 (CBNZ)
//   uncondbranch       unconditional PC-relative branch (B/BL)
//   zero               ALU zero flag
//   link               with uncondbranch, push PC+4 onto the RAS (BL)
//   ret                pop the RAS into the PC (RET)
//   sign_extend        sign-extended word offset
//   pc                 current PC (registered)
//   taken              PC was redirected on the last update (registered)
//   ras_empty/ras_full stack occupancy (combinational from count)
//   ras_overflow       sticky, push while full
//   ras_underflow      sticky, ret while empty
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch,
  input  logic              branch_not_zero,
  input  logic              uncondbranch,
  input  logic              zero,
  input  logic              link,
  input  logic              ret,
  input  logic [ADDR_W-1:0] sign_extend,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] stack_mem [RAS_DEPTH];
  // top_ptr addresses the next free slot; the newest entry sits at top_ptr-1.
  // Because the depth is a power of two the pointer wraps naturally, so a
  // push while full simply overwrites the oldest entry.
  logic [PTR_W-1:0]  top_ptr;
  logic [CNT_W-1:0]  count;

  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pop_data;
  logic              cond_taken;
  logic              br_taken;
  logic              do_push;

  always_comb begin
    seq        = pc + ADDR_W'(4);
    target     = pc + (sign_extend << 2);
    cond_taken = branch & (zero ^ branch_not_zero);
    br_taken   = uncondbranch | cond_taken;
    // ret has priority, so a RET in the same cycle as a BL suppresses the push
    do_push    = uncondbranch & link & ~ret;
    pop_data   = stack_mem[top_ptr - PTR_W'(1)];
    ras_empty  = (count == '0);
    ras_full   = (count == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      taken         <= 1'b0;
      count         <= '0;
      top_ptr       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (!ras_empty) begin
          pc      <= pop_data;
          taken   <= 1'b1;
          count   <= count - CNT_W'(1);
          top_ptr <= top_ptr - PTR_W'(1);
        end else begin
          pc            <= seq;
          taken         <= 1'b0;
          ras_underflow <= 1'b1;
        end
      end else if (br_taken) begin
        pc    <= target;
        taken <= 1'b1;
        if (do_push) begin
          top_ptr <= top_ptr + PTR_W'(1);
          if (ras_full) begin
            ras_overflow <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
      end else begin
        pc    <= seq;
        taken <= 1'b0;
      end
    end
  end

  // Entry storage carries no reset; contents are never read while count is 0.
  always_ff @(posedge clk) begin
    if (!reset && !stall && do_push) begin
      stack_mem[top_ptr] <= seq;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized stimulus
// compared against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch, branch_not_zero, uncondbranch, zero, link, ret;
  logic [31:0] sign_extend;
  logic [31:0] pc;
  logic        taken, ras_empty, ras_full, ras_overflow, ras_underflow;

  // second instance for the 16-bit wrap-around case
  logic        reset16 = 1'b1, ub16 = 1'b0, zero16 = 1'b0;
  logic [15:0] se16 = '0;
  logic [15:0] pc16;
  logic        taken16, empty16, full16, ovf16, unf16;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_taken, m_ovf, m_unf;
  logic [31:0] m_stack[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_not_zero(branch_not_zero), .uncondbranch(uncondbranch), .zero(zero),
    .link(link), .ret(ret), .sign_extend(sign_extend), .pc(pc), .taken(taken),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.ADDR_W(16), .RAS_DEPTH(2)) dut16 (
    .clk(clk), .reset(reset16), .stall(zero16), .branch(zero16),
    .branch_not_zero(zero16), .uncondbranch(ub16), .zero(zero16),
    .link(zero16), .ret(zero16), .sign_extend(se16), .pc(pc16), .taken(taken16),
    .ras_empty(empty16), .ras_full(full16), .ras_overflow(ovf16),
    .ras_underflow(unf16)
  );

  // Apply one cycle of inputs, wait for the edge, sample 1 time unit later
  // and advance the reference model by the same edge.
  task automatic drive(input logic rs, st, br, bnz, ub, z, lk, rt, input logic [31:0] se);
    logic [31:0] seqv, tgt;
    logic        brt;
    reset = rs; stall = st; branch = br; branch_not_zero = bnz;
    uncondbranch = ub; zero = z; link = lk; ret = rt; sign_extend = se;
    @(posedge clk);
    #1;
    if (rs) begin
      m_pc = 32'h0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_stack.delete();
    end else if (!st) begin
      seqv = m_pc + 32'd4;
      tgt  = m_pc + (se << 2);
      brt  = ub | (br & (z != bnz));
      if (rt) begin
        if (m_stack.size() > 0) begin
          m_pc = m_stack.pop_back(); m_taken = 1'b1;
        end else begin
          m_pc = seqv; m_taken = 1'b0; m_unf = 1'b1;
        end
      end else if (brt) begin
        m_pc = tgt; m_taken = 1'b1;
        if (ub && lk) begin
          m_stack.push_back(seqv);
          if (m_stack.size() > 4) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
        end
      end else begin
        m_pc = seqv; m_taken = 1'b0;
      end
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    vectors++;
    if (pc !== 32'h0 || taken !== 1'b0 || ras_empty !== 1'b1 || ras_full !== 1'b0 ||
        ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: pc=%h taken=%b empty=%b full=%b ovf=%b unf=%b, want pc=0 taken=0 empty=1 others 0",
               pc, taken, ras_empty, ras_full, ras_overflow, ras_underflow);
    end
    for (int i = 1; i <= 3; i++) begin
      idle();
      exp_pc = 32'(i * 4);
      vectors++;
      if (pc !== exp_pc || taken !== 1'b0 || ras_empty !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_idle%0d: pc=%h taken=%b empty=%b, want pc=%h taken=0 empty=1",
                 i, pc, taken, ras_empty, exp_pc);
      end
    end
  endtask

  task automatic test_cond_branch();
    idle();  // pc 0xC -> 0x10
    drive(0, 0, 1, 0, 0, 1, 0, 0, 32'd3);  // CBZ taken
    vectors++;
    if (pc !== 32'h1C || taken !== 1'b1) begin
      miscompares++;
      $display("FAIL cbz_taken: pc=%h taken=%b, want pc=1c taken=1", pc, taken);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFD);  // B back to 0x10
    drive(0, 0, 1, 0, 0, 0, 0, 0, 32'd3);  // CBZ not taken
    vectors++;
    if (pc !== 32'h14 || taken !== 1'b0) begin
      miscompares++;
      $display("FAIL cbz_not_taken: pc=%h taken=%b, want pc=14 taken=0", pc, taken);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF);  // B back to 0x10
    drive(0, 0, 1, 1, 0, 0, 0, 0, 32'd3);  // CBNZ taken
    vectors++;
    if (pc !== 32'h1C || taken !== 1'b1) begin
      miscompares++;
      $display("FAIL cbnz_taken: pc=%h taken=%b, want pc=1c taken=1", pc, taken);
    end
    drive(0, 0, 1, 1, 0, 1, 0, 0, 32'd3);  // CBNZ not taken
    vectors++;
    if (pc !== 32'h20 || taken !== 1'b0) begin
      miscompares++;
      $display("FAIL cbnz_not_taken: pc=%h taken=%b, want pc=20 taken=0", pc, taken);
    end
  endtask

  task automatic test_bl_ret();
    drive(0, 0, 0, 0, 1, 0, 1, 0, 32'h10);  // BL at 0x20
    vectors++;
    if (pc !== 32'h60 || taken !== 1'b1 || ras_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL bl: pc=%h taken=%b empty=%b, want pc=60 taken=1 empty=0", pc, taken, ras_empty);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);  // RET
    vectors++;
    if (pc !== 32'h24 || taken !== 1'b1 || ras_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ret: pc=%h taken=%b empty=%b, want pc=24 taken=1 empty=1", pc, taken, ras_empty);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 1, 0, 1, 0, 32'd1);  // BL pushes 0x28..0x38
      vectors++;
      if (ras_full !== (i >= 4) || ras_overflow !== (i == 5)) begin
        miscompares++;
        $display("FAIL push%0d: full=%b ovf=%b, want full=%b ovf=%b",
                 i, ras_full, ras_overflow, i >= 4, i == 5);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
      exp_pc = 32'h38 - 32'(i * 4);
      vectors++;
      if (pc !== exp_pc || taken !== 1'b1) begin
        miscompares++;
        $display("FAIL pop%0d: pc=%h taken=%b, want pc=%h taken=1", i, pc, taken, exp_pc);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0);  // underflow
    vectors++;
    if (pc !== 32'h30 || taken !== 1'b0 || ras_underflow !== 1'b1 || ras_empty !== 1'b1 ||
        ras_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow: pc=%h taken=%b unf=%b empty=%b ovf=%b, want pc=30 taken=0 unf=1 empty=1 ovf=1",
               pc, taken, ras_underflow, ras_empty, ras_overflow);
    end
  endtask

  task automatic test_stall();
    drive(0, 0, 0, 0, 1, 0, 1, 0, 32'd2);  // BL 0x30 -> 0x38, push 0x34
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 1, 1, 1, (i == 2), 32'd5);
      vectors++;
      if (pc !== 32'h38 || taken !== 1'b1 || ras_empty !== 1'b0 || ras_full !== 1'b0 ||
          ras_overflow !== 1'b1 || ras_underflow !== 1'b1) begin
        miscompares++;
        $display("FAIL stall%0d: pc=%h taken=%b empty=%b full=%b ovf=%b unf=%b, want pc=38 taken=1 empty=0 full=0 ovf=1 unf=1",
                 i, pc, taken, ras_empty, ras_full, ras_overflow, ras_underflow);
      end
    end
    drive(1, 1, 0, 0, 1, 0, 1, 0, 32'd5);  // reset beats stall and BL
    vectors++;
    if (pc !== 32'h0 || taken !== 1'b0 || ras_empty !== 1'b1 || ras_overflow !== 1'b0 ||
        ras_underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_reset: pc=%h taken=%b empty=%b ovf=%b unf=%b, want pc=0 taken=0 empty=1 ovf=0 unf=0",
               pc, taken, ras_empty, ras_overflow, ras_underflow);
    end
  endtask

  task automatic test_wrap16();
    logic [15:0] exp16 [4] = '{16'hFFFC, 16'hFFF8, 16'hFFFC, 16'h0000};
    logic [15:0] se_tab [4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
    logic        ub_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    reset16 = 1'b1; ub16 = 1'b0; se16 = '0;
    idle();
    vectors++;
    if (pc16 !== 16'h0) begin
      miscompares++;
      $display("FAIL wrap16_reset: pc=%h, want 0000", pc16);
    end
    reset16 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ub16 = ub_tab[i]; se16 = se_tab[i];
      idle();
      vectors++;
      if (pc16 !== exp16[i]) begin
        miscompares++;
        $display("FAIL wrap16_step%0d: pc=%h, want %h", i, pc16, exp16[i]);
      end
    end
    ub16 = 1'b0;
  endtask

  task automatic test_random();
    logic        rs, st, br, bnz, ub, z, lk, rt;
    logic [31:0] se;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int n = 0; n < 600; n++) begin
      rs  = ($urandom_range(0, 63) == 0);
      st  = ($urandom_range(0, 7) == 0);
      br  = $urandom_range(0, 1);
      bnz = $urandom_range(0, 1);
      z   = $urandom_range(0, 1);
      ub  = ($urandom_range(0, 2) == 0);
      lk  = ($urandom_range(0, 3) != 0);
      rt  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) se = $urandom();
      else begin se = $urandom_range(0, 63); se = se - 32'd32; end
      drive(rs, st, br, bnz, ub, z, lk, rt, se);
      vectors++;
      if (pc !== m_pc || taken !== m_taken || ras_empty !== (m_stack.size() == 0) ||
          ras_full !== (m_stack.size() == 4) || ras_overflow !== m_ovf ||
          ras_underflow !== m_unf) begin
        miscompares++;
        $display("FAIL random%0d: pc=%h taken=%b empty=%b full=%b ovf=%b unf=%b, want pc=%h taken=%b empty=%b full=%b ovf=%b unf=%b",
                 n, pc, taken, ras_empty, ras_full, ras_overflow, ras_underflow,
                 m_pc, m_taken, m_stack.size() == 0, m_stack.size() == 4, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; branch_not_zero = 1'b0;
    uncondbranch = 1'b0; zero = 1'b0; link = 1'b0; ret = 1'b0; sign_extend = '0;
    m_pc = '0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    test_reset();
    test_cond_branch();
    test_bl_ret();
    test_overflow();
    test_stall();
    test_wrap16();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32: width of PC, offset and stack entries.
REQ-002 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, minimum 2.
REQ-003 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  hold all state this cycle.
REQ-007 branch  input  1  conditional branch (CBZ/CBNZ) in this cycle.
REQ-008 branch_not_zero  input  1  0 = take on zero=1 (CBZ); 1 = take on zero=0 (CBNZ).
REQ-009 uncondbranch  input  1  unconditional PC-relative branch (B/BL).
REQ-010 zero  input  1  ALU zero flag.
REQ-011 link  input  1  with uncondbranch: push PC+4 onto return stack (BL).
REQ-012 ret  input  1  pop return stack into PC (RET).
REQ-013 sign_extend  input  ADDR_W  sign-extended word offset.
REQ-014 pc  output  ADDR_W  current PC, registered.
REQ-015 taken  output  1  registered; 1 when the PC was redirected (branch or ret) on the last update.
REQ-016 ras_empty  output  1  combinational from stack count: count == 0.
REQ-017 ras_full  output  1  combinational from stack count: count == RAS_DEPTH.
REQ-018 ras_overflow  output  1  sticky; set on a push while full.
REQ-019 ras_underflow  output  1  sticky; set on a ret while empty.

Function
REQ-020 seq = pc + 4; target = pc + (sign_extend << 2); both truncated to ADDR_W, wrapping modulo 2^ADDR_W.
REQ-021 cond_taken = branch & (zero ^ branch_not_zero); br_taken = uncondbranch | cond_taken.
REQ-022 Next-PC priority per edge: reset > stall > ret > br_taken > seq.
REQ-023 stall=1: pc, taken, stack contents, stack count and sticky flags all hold; other inputs ignored.
REQ-024 ret=1 with stack non-empty: pc <= top entry, count decrements, taken <= 1.
REQ-025 ret=1 with stack empty: pc <= seq, ras_underflow <= 1, taken <= 0, count stays 0.
REQ-026 ret=1 overrides branch, uncondbranch and link in the same cycle; no push occurs.
REQ-027 br_taken=1 and ret=0: pc <= target, taken <= 1.
REQ-028 link=1 and uncondbranch=1 and ret=0: push seq (address after the BL) onto the stack.
REQ-029 Push while not full: count increments; push while full: oldest entry discarded (circular overwrite), count stays RAS_DEPTH, ras_overflow <= 1.
REQ-030 link=1 without uncondbranch: ignored; no push.
REQ-031 Otherwise: pc <= seq, taken <= 0.
REQ-032 Stack is LIFO: top pointer wraps modulo RAS_DEPTH; pops after overflow return most-recent entries first.
REQ-033 pc changes only on a clock edge; no combinational path from any input to pc or taken.
REQ-034 Pop data is the entry pushed most recently and not yet popped; a push and a pop never occur together.

Reset
REQ-035 reset=1 at an edge: pc <= RESET_PC, taken <= 0, count <= 0, top pointer <= 0, ras_overflow <= 0, ras_underflow <= 0.
REQ-036 reset overrides stall and all control inputs, including mid-push or mid-branch.
REQ-037 Stack entry storage needs no reset; entries are unreadable while count == 0.

Verification
REQ-038 Reset, then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC; taken=0; ras_empty=1.
REQ-039 At pc=0x10: branch=1, zero=1, branch_not_zero=0, sign_extend=3 -> pc=0x1C, taken=1; repeat with zero=0 -> pc=0x14, taken=0; with branch_not_zero=1, zero=0 -> pc=0x1C.
REQ-040 At pc=0x20: uncondbranch=1, link=1, sign_extend=0x10 -> pc=0x60, stack top 0x24; next cycle ret=1 -> pc=0x24, ras_empty=1, taken=1.
REQ-041 RAS_DEPTH=4: five BLs pushing A,B,C,D,E -> ras_overflow=1, ras_full=1; four rets -> pc sequence E,D,C,B; fifth ret -> pc=last+4, ras_underflow=1.
REQ-042 stall=1 held 3 cycles with uncondbranch=1 -> pc, count, taken unchanged; reset=1 during stall -> pc=RESET_PC, flags cleared next edge.
REQ-043 ADDR_W=16, pc=0xFFFC, sign_extend=0xFFFF (-1) -> pc=0xFFF8; idle from pc=0xFFFC -> pc=0x0000.
